// File: rtl/mem_burst_pkg.sv
// Shared types for the burst memory reader: access-size codes, FSM states,
// buffered word format and the size-to-length decode.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        SIZE_1W  = 2'b00,
        SIZE_4W  = 2'b01,
        SIZE_8W  = 2'b10,
        SIZE_16W = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RECV,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        last;
    } fifo_entry_t;

    function automatic logic [4:0] burst_len(input logic [1:0] size);
        case (size)
            SIZE_1W:  return 5'd1;
            SIZE_4W:  return 5'd4;
            SIZE_8W:  return 5'd8;
            default:  return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Word buffer between the memory responder and the fetch stage; clear drops
// every entry at the next edge.
module burst_fifo
    import mem_burst_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  fifo_entry_t   push_entry,
    input  logic          pop,
    output fifo_entry_t   head,
    output logic          empty,
    output logic [CW-1:0] free_count
);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign do_push    = push && (count != CW'(DEPTH));
    assign do_pop     = pop && (count != '0);
    assign empty      = (count == '0);
    assign free_count = CW'(DEPTH) - count;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues one read burst per accepted line-fill request
// and buffers returned words for the fetch stage.
module mem_burst_reader
    import mem_burst_pkg::*;
#(
    parameter logic [31:0] base_addr  = 32'h80020000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        flush,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic        mem_busy,
    input  logic [31:0] mem_data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_last
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state, state_next;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [4:0]    len_q, len_d;
    logic [4:0]    k_q, k_d;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] free_count;
    fifo_entry_t   push_entry;
    fifo_entry_t   head;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    // Whole-burst space is reserved up front because mem_busy cannot be throttled.
    assign req_ready = (state == IDLE) && !flush
                    && (32'(free_count) >= 32'(burst_len(req_size)));
    assign accept    = req_valid && req_ready;

    assign mem_address     = addr_q;
    assign mem_access_size = size_q;
    assign mem_rw          = 1'b1;
    assign mem_enable      = (state == ISSUE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            addr_q <= base_addr;
            size_q <= '0;
            len_q  <= '0;
            k_q    <= '0;
        end else begin
            state  <= state_next;
            addr_q <= addr_d;
            size_q <= size_d;
            len_q  <= len_d;
            k_q    <= k_d;
        end
    end

    always_comb begin
        state_next = state;
        addr_d     = addr_q;
        size_d     = size_q;
        len_d      = len_q;
        k_d        = k_q;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                    addr_d     = {req_addr[31:2], 2'b00};
                    size_d     = req_size;
                    len_d      = burst_len(req_size);
                    k_d        = '0;
                end
            end
            ISSUE: state_next = flush ? DRAIN : RECV;
            RECV: begin
                if (mem_busy) begin
                    push = !flush;
                    k_d  = k_q + 5'd1;
                end
                if (mem_busy && (k_q == len_q - 5'd1)) state_next = IDLE;
                else if (flush)                        state_next = DRAIN;
            end
            DRAIN: begin
                if (mem_busy) begin
                    k_d = k_q + 5'd1;
                    if (k_q == len_q - 5'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign push_entry = '{data: mem_data_out,
                          addr: addr_q + {25'b0, k_q, 2'b00},
                          last: (k_q == len_q - 5'd1)};
    assign pop        = out_ready && !fifo_empty;

    burst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .free_count (free_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : head.data;
    assign out_addr  = fifo_empty ? '0 : head.addr;
    assign out_last  = fifo_empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader; a queue of expected buffered words and
// a burst bookkeeping model predict every output each cycle.
module tb_mem_burst_reader;

    localparam logic [31:0] BASE  = 32'h80020000;
    localparam int          DEPTH = 16;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        flush;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic        out_last;

    mem_burst_reader #(.base_addr(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_size        (req_size),
        .flush           (flush),
        .mem_address     (mem_address),
        .mem_access_size (mem_access_size),
        .mem_rw          (mem_rw),
        .mem_enable      (mem_enable),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_addr        (out_addr),
        .out_last        (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    bit          issue_pending = 0;
    int          outstanding   = 0;
    int          got           = 0;
    int          stale         = 0;
    bit          discard       = 0;
    logic [31:0] bbase         = '0;
    logic [1:0]  bsize         = '0;

    int          p_req = 0, p_busy = 100, p_ready = 100, p_flush = 0, flush_at = -1;
    bit          f_req = 0;
    logic [31:0] f_addr = '0;
    logic [1:0]  f_size = '0;
    bit          f_data_en = 0;
    logic [31:0] f_data = '0;

    function automatic int blen(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (2 << s);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        bit idle, word, acc, exp_ready;
        idle  = (outstanding == 0) && !issue_pending;
        flush = (p_flush > 0) && ($urandom_range(99) < p_flush);
        if (flush_at >= 0 && !issue_pending && outstanding > 0 && got == flush_at) begin
            flush    = 1'b1;
            flush_at = -1;
        end
        req_addr = $urandom;
        req_size = 2'($urandom_range(3));
        if (f_req) begin
            req_valid = 1'b1;
            req_addr  = f_addr;
            req_size  = f_size;
        end else begin
            req_valid = (stale == 0) && ($urandom_range(99) < p_req);
        end
        out_ready    = ($urandom_range(99) < p_ready);
        word         = !flush && (((outstanding > 0) && !issue_pending) || (stale > 0))
                       && ($urandom_range(99) < p_busy);
        mem_busy     = word;
        mem_data_out = f_data_en ? f_data : $urandom;
        #1;
        exp_ready = idle && !flush && ((DEPTH - q.size()) >= blen(req_size));
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", 64'(out_data), 64'(q[0].data));
            check("out_addr", 64'(out_addr), 64'(q[0].addr));
            check("out_last", 64'(out_last), 64'(q[0].last));
        end
        check("mem_enable", 64'(mem_enable), 64'(issue_pending));
        if (issue_pending) begin
            check("mem_address", 64'(mem_address), 64'(bbase));
            check("mem_access_size", 64'(mem_access_size), 64'(bsize));
            check("mem_rw", 64'(mem_rw), 64'd1);
        end
        acc = req_valid && exp_ready;
        @(posedge clock);
        if (flush) q.delete();
        else begin
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (word && outstanding > 0 && !discard)
                q.push_back('{mem_data_out, bbase + 32'(got) * 32'd4, got == blen(bsize) - 1});
        end
        if (word) begin
            if (outstanding > 0) begin
                got++;
                outstanding--;
            end else stale--;
        end
        if (flush && (issue_pending || outstanding > 0)) discard = 1;
        issue_pending = 0;
        if (acc) begin
            issue_pending = 1;
            outstanding   = blen(req_size);
            got           = 0;
            discard       = 0;
            bbase         = {req_addr[31:2], 2'b00};
            bsize         = req_size;
            f_req         = 0;
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic settle(input int limit);
        int c;
        c = 0;
        while ((outstanding > 0 || issue_pending || f_req || stale > 0) && c < limit) begin
            cycle();
            c++;
        end
        check("settle_timeout", 64'(c < limit), 64'd1);
    endtask

    task automatic apply_reset();
        req_valid = 0;
        flush     = 0;
        mem_busy  = 0;
        reset_n   = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_mem_enable", 64'(mem_enable), 64'd0);
        check("rst_mem_rw", 64'(mem_rw), 64'd1);
        check("rst_mem_access_size", 64'(mem_access_size), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'(BASE));
        stale         = outstanding;
        q.delete();
        issue_pending = 0;
        outstanding   = 0;
        got           = 0;
        discard       = 0;
        f_req         = 0;
        flush_at      = -1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic request(input logic [31:0] a, input logic [1:0] s);
        f_req  = 1;
        f_addr = a;
        f_size = s;
    endtask

    initial begin
        reset_n = 0; req_valid = 0; req_addr = '0; req_size = '0; flush = 0;
        mem_busy = 0; mem_data_out = '0; out_ready = 0;
        @(negedge clock);
        apply_reset();

        // single word, zero-wait responder
        f_data_en = 1; f_data = 32'h3C1D8002;
        request(32'h80020000, 2'b00);
        run(6);
        f_data_en = 0;

        // 16-word burst held in the buffer, then released
        p_ready = 0;
        request(32'h80020040, 2'b11);
        settle(60);
        p_req = 100;
        run(8);
        p_req = 0; p_ready = 100;
        run(20);

        // 4-word burst with responder waits
        p_busy = 50; p_ready = 70;
        request(32'h80021000, 2'b01);
        settle(100);
        run(6);

        // flush after 3 of 8 words
        p_busy = 100; p_ready = 0; flush_at = 3;
        request(32'h80022000, 2'b10);
        settle(60);
        p_ready = 100;
        request(32'h80023000, 2'b01);
        settle(60);
        run(6);

        // reset mid-burst, stale words must be ignored
        p_busy = 60; p_ready = 50;
        request(32'h80024000, 2'b11);
        for (int i = 0; i < 60 && !(outstanding > 0 && got >= 5); i++) cycle();
        apply_reset();
        @(negedge clock);
        settle(100);
        run(4);

        // address wrap
        p_busy = 100; p_ready = 100;
        request(32'hFFFFFFF8, 2'b01);
        settle(40);
        run(6);

        // random traffic
        p_req = 30; p_busy = 70; p_ready = 60; p_flush = 3;
        run(3000);
        p_req = 0; p_flush = 0; p_ready = 100;
        settle(200);
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
